// File: rtl/crc_check.sv
// crc_check: serial CRC5/CRC16 receive checker for USB-style packets.
// Bits arrive one per clk; the result is reported one cycle after recving falls.
//
// Ports:
//   clk      in   clock; all state updates on the rising edge
//   rst_L    in   asynchronous active-low reset
//   inb      in   received serial bit (NRZI-decoded, unstuffed)
//   recving  in   high while packet bits arrive; falling edge ends the packet
//   start    in   high while inb carries SYNC/PID bits (kept out of the CRC)
//   pause    in   high when inb is a dead (stuffed-bit) slot
//   crc16    in   0 = CRC5 token check, 1 = CRC16 data check; sampled at packet start
//   busy     out  high while a packet is being checked
//   done     out  one-cycle pulse when crc_ok/crc_err are freshly valid
//   crc_ok   out  last check passed; held until the next done
//   crc_err  out  last check failed; held until the next done

module crc_check (
    input  logic clk,
    input  logic rst_L,
    input  logic inb,
    input  logic recving,
    input  logic start,
    input  logic pause,
    input  logic crc16,
    output logic busy,
    output logic done,
    output logic crc_ok,
    output logic crc_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam logic [4:0]  CRC5_INIT  = 5'b11111;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;
    localparam logic [4:0]  CRC5_POLY  = 5'b00101;
    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [4:0]  CRC5_RES   = 5'b01100;
    localparam logic [15:0] CRC16_RES  = 16'h800D;
    localparam logic [4:0]  CRC5_MIN   = 5'd5;
    localparam logic [4:0]  CRC16_MIN  = 5'd16;
    localparam logic [4:0]  CNT_MAX    = 5'd31;

    state_t      state;
    logic        mode;
    logic [4:0]  crc5_r;
    logic [15:0] crc16_r;
    logic [4:0]  cnt;

    logic        qual;
    logic [4:0]  base5;
    logic [15:0] base16;
    logic [4:0]  base_cnt;
    logic [4:0]  nxt5;
    logic [15:0] nxt16;
    logic [4:0]  nxt_cnt;
    logic        pass5;
    logic        pass16;
    logic        pass;

    function automatic logic [4:0] crc5_step(
        input logic [4:0] r,
        input logic       b
    );
        logic fb;
        fb = r[4] ^ b;
        return {r[3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'b0);
    endfunction

    function automatic logic [15:0] crc16_step(
        input logic [15:0] r,
        input logic        b
    );
        logic fb;
        fb = r[15] ^ b;
        return {r[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'b0);
    endfunction

    // A bit counts only when it is real payload: not SYNC/PID, not a
    // stuffed slot. Entry from IDLE accumulates onto the preset values,
    // so the first qualified bit may coincide with the IDLE->CHECK edge.
    always_comb begin
        qual     = recving & ~start & ~pause;
        base5    = (state == IDLE) ? CRC5_INIT  : crc5_r;
        base16   = (state == IDLE) ? CRC16_INIT : crc16_r;
        base_cnt = (state == IDLE) ? 5'd0       : cnt;
        nxt5     = crc5_step(base5, inb);
        nxt16    = crc16_step(base16, inb);
        nxt_cnt  = (base_cnt == CNT_MAX) ? CNT_MAX : base_cnt + 5'd1;
    end

    // Short packets fail regardless of what the register holds.
    always_comb begin
        pass5  = (crc5_r  == CRC5_RES)  && (cnt >= CRC5_MIN);
        pass16 = (crc16_r == CRC16_RES) && (cnt >= CRC16_MIN);
        pass   = mode ? pass16 : pass5;
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state   <= IDLE;
            mode    <= 1'b0;
            crc5_r  <= CRC5_INIT;
            crc16_r <= CRC16_INIT;
            cnt     <= 5'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            crc_ok  <= 1'b0;
            crc_err <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (recving) begin
                        state   <= CHECK;
                        busy    <= 1'b1;
                        mode    <= crc16;
                        crc5_r  <= qual ? nxt5    : CRC5_INIT;
                        crc16_r <= qual ? nxt16   : CRC16_INIT;
                        cnt     <= qual ? nxt_cnt : 5'd0;
                    end else begin
                        crc5_r  <= CRC5_INIT;
                        crc16_r <= CRC16_INIT;
                        cnt     <= 5'd0;
                    end
                end
                CHECK: begin
                    if (!recving) begin
                        state   <= REPORT;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        crc_ok  <= pass;
                        crc_err <= ~pass;
                    end else if (qual) begin
                        crc5_r  <= nxt5;
                        crc16_r <= nxt16;
                        cnt     <= nxt_cnt;
                    end
                end
                REPORT: begin
                    // Any bit offered here is dropped; a new packet
                    // must be seen from IDLE.
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
